// File: rtl/wb_bram_slave.sv
// Wishbone slave over a single-port BRAM; optional CTI incrementing bursts under `WB_BRAM_BURST_EN.
// First ack 1 clk after req, then 1 beat/clk in bursts (1 beat/2 clk classic); ack is gated by req.
module wb_bram_slave #(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic [2:0]  wb_cti_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o
);
    localparam int DEPTH = 2**adr_width;

    typedef enum logic [1:0] {
        IDLE,
        ACK
`ifdef WB_BRAM_BURST_EN
        , BURST
`endif
    } state_t;

    logic [31:0]          mem [DEPTH];
    state_t               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [31:0]          dat_q;
    logic [adr_width-1:0] adr_word;
    logic [adr_width-1:0] rd_addr;
    logic                 req;
    logic                 wr_beat;
    logic                 unused_bits;

    assign req      = wb_cyc_i & wb_stb_i;
    assign adr_word = wb_adr_i[adr_width+1:2];
    assign wb_ack_o = ack_q & req;
    assign wb_dat_o = dat_q;
    assign wr_beat  = wb_ack_o & wb_we_i;

`ifdef WB_BRAM_BURST_EN
    localparam logic [2:0] CTI_INC = 3'b010;

    // Word address of the beat being acked this clk while in BURST.
    logic [adr_width-1:0] cnt_q, cnt_d;

    assign unused_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};
`else
    assign unused_bits = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0], wb_cti_i};
`endif

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        rd_addr = adr_word;
`ifdef WB_BRAM_BURST_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    ack_d = 1'b1;
`ifdef WB_BRAM_BURST_EN
                    if (wb_cti_i == CTI_INC) begin
                        state_d = BURST;
                        cnt_d   = adr_word;
                    end else begin
                        state_d = ACK;
                    end
`else
                    state_d = ACK;
`endif
                end
            end
            ACK: state_d = IDLE;
`ifdef WB_BRAM_BURST_EN
            BURST: begin
                // Prefetch the next sequential word so it is ready on the following beat.
                rd_addr = cnt_q + 1'b1;
                if (req && (wb_cti_i == CTI_INC)) begin
                    ack_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
`ifdef WB_BRAM_BURST_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (ack_d) begin
                dat_q <= mem[rd_addr];
            end
`ifdef WB_BRAM_BURST_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) begin
                    mem[adr_word][8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_bram_slave.sv
// Bench for wb_bram_slave: directed scenarios plus random classic/burst traffic against a word-array model.
module tb_wb_bram_slave;

`ifdef WB_BRAM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif
    localparam int WORDS = 2048;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    logic [31:0] mdl [WORDS];
    logic [18:0] hi_bits;
    logic [31:0] last_rd;
    int          checks;
    int          errors;

    wb_bram_slave #(.adr_width(11)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_cti_i (wb_cti_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] sel);
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic drive(input bit we, input int word, input logic [31:0] d,
                         input logic [3:0] sel, input logic [2:0] cti);
        int w;
        w        = word & (WORDS - 1);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {hi_bits, w[10:0], 2'b00};
        wb_dat_i = d;
        wb_sel_i = sel;
        wb_cti_i = cti;
    endtask

    task automatic idle();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_cti_i = 3'b000;
    endtask

    // Single-beat cycle: ack must be absent in the request clk, present in the next, gone after.
    task automatic classic(input bit we, input int word, input logic [31:0] d, input logic [3:0] sel,
                           input logic [2:0] cti, input string tag);
        int w;
        w = word & (WORDS - 1);
        @(posedge sys_clk); #1;
        drive(we, w, d, sel, cti);
        @(negedge sys_clk);
        chk({tag, "_lat"}, {31'b0, wb_ack_o}, 32'd0);
        @(negedge sys_clk);
        chk({tag, "_ack"}, {31'b0, wb_ack_o}, 32'd1);
        if (we) begin
            model_write(w, d, sel);
        end else begin
            chk({tag, "_rdata"}, wb_dat_o, mdl[w]);
            last_rd = wb_dat_o;
        end
        @(posedge sys_clk); #1;
        idle();
        @(negedge sys_clk);
        chk({tag, "_ack_end"}, {31'b0, wb_ack_o}, 32'd0);
    endtask

    // Incrementing burst of n beats; drop_after > 0 releases cyc after that many acked beats.
    task automatic burst(input bit we, input int start, input int n, input int drop_after,
                         input logic [3:0] sel, input string tag);
        int beat;
        int cyc_n;
        int target;
        int w;
        bit acked;
        beat   = 0;
        cyc_n  = 0;
        target = (drop_after > 0) ? drop_after : n;
        @(posedge sys_clk); #1;
        drive(we, start, $urandom, sel, (n == 1) ? 3'b111 : 3'b010);
        while (beat < target && cyc_n < 4*n + 8) begin
            @(negedge sys_clk);
            acked = wb_ack_o;
            if (acked) begin
                chk({tag, "_ack_cycle"}, cyc_n, BURST_EN ? beat + 1 : 2*beat + 1);
                w = (start + beat) & (WORDS - 1);
                if (we) model_write(w, wb_dat_i, wb_sel_i);
                else    chk({tag, "_rdata"}, wb_dat_o, mdl[w]);
                beat++;
            end
            @(posedge sys_clk); #1;
            cyc_n++;
            if (acked && beat < target)
                drive(we, start + beat, $urandom, sel, (beat == n - 1) ? 3'b111 : 3'b010);
        end
        idle();
        chk({tag, "_beats"}, beat, target);
        @(negedge sys_clk);
        chk({tag, "_ack_end"}, {31'b0, wb_ack_o}, 32'd0);
    endtask

    initial begin
        int op;
        int n;
        logic [2:0] cti;
        logic [2:0] classic_cti [7];
        classic_cti = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
        checks   = 0;
        errors   = 0;
        hi_bits  = '0;
        last_rd  = '0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        idle();
        sys_rst  = 1'b0;

        repeat (3) @(negedge sys_clk);
        chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("post_rst_dat", wb_dat_o, 32'd0);

        // Fill the whole array so every later read has a defined expectation.
        burst(1'b1, 0, WORDS, 0, 4'hF, "init");
        burst(1'b0, WORDS - 16, 20, 0, 4'hF, "init_rd");

        classic(1'b1, 4, 32'hDEADBEEF, 4'hF, 3'b000, "t1_wr");
        classic(1'b0, 4, 32'h0, 4'hF, 3'b000, "t1_rd");
        chk("t1_value", last_rd, 32'hDEADBEEF);

        classic(1'b1, 4, 32'h0000AA00, 4'b0010, 3'b000, "t2_wr");
        classic(1'b0, 4, 32'h0, 4'hF, 3'b000, "t2_rd");
        chk("t2_value", last_rd, 32'hDEADAAEF);

        for (int i = 0; i < 4; i++) classic(1'b1, 64 + i, i + 1, 4'hF, 3'b000, "t3_wr");
        burst(1'b0, 64, 4, 0, 4'hF, "t3_rd");

        burst(1'b1, WORDS - 1, 2, 0, 4'hF, "t4_wr");
        burst(1'b0, WORDS - 1, 2, 0, 4'hF, "t4_rd");
        classic(1'b0, 0, 32'h0, 4'hF, 3'b000, "t4_word0");

        burst(1'b1, 8, 4, 2, 4'hF, "t5_wr");
        classic(1'b0, 10, 32'h0, 4'hF, 3'b000, "t5_w2");
        classic(1'b0, 11, 32'h0, 4'hF, 3'b000, "t5_w3");
        classic(1'b0, 8, 32'h0, 4'hF, 3'b000, "t5_w0");

        // Reset lands in the clk where the second write beat would be acked.
        @(posedge sys_clk); #1;
        drive(1'b1, 200, 32'h11112222, 4'hF, 3'b010);
        @(negedge sys_clk);
        chk("t6_lat", {31'b0, wb_ack_o}, 32'd0);
        @(negedge sys_clk);
        chk("t6_beat1_ack", {31'b0, wb_ack_o}, 32'd1);
        model_write(200, 32'h11112222, 4'hF);
        @(posedge sys_clk); #1;
        drive(1'b1, 201, 32'h33334444, 4'hF, 3'b010);
        repeat (BURST_EN ? 0 : 1) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("t6_rst_ack", {31'b0, wb_ack_o}, 32'd0);
        chk("t6_rst_dat", wb_dat_o, 32'd0);
        @(posedge sys_clk); #1;
        idle();
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("t6_idle_ack", {31'b0, wb_ack_o}, 32'd0);
        classic(1'b0, 200, 32'h0, 4'hF, 3'b000, "t6_w0");
        chk("t6_w0_value", last_rd, 32'h11112222);
        classic(1'b0, 201, 32'h0, 4'hF, 3'b000, "t6_w1");

        for (int i = 0; i < 150; i++) begin
            hi_bits = 19'($urandom);
            op      = $urandom_range(0, 3);
            n       = $urandom_range(1, 8);
            cti     = classic_cti[$urandom_range(0, 6)];
            case (op)
                0: classic(1'b1, $urandom_range(0, WORDS - 1), $urandom, 4'($urandom), cti, "rnd_cwr");
                1: classic(1'b0, $urandom_range(0, WORDS - 1), 32'h0, 4'($urandom), cti, "rnd_crd");
                2: burst(1'b1, $urandom_range(WORDS - 12, WORDS + 12), n, 0, 4'($urandom), "rnd_bwr");
                default: burst(1'b0, $urandom_range(WORDS - 12, WORDS + 12), n, 0, 4'hF, "rnd_brd");
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
